// File: rtl/alu_md_sequencer.sv
// alu_md_sequencer
//   Iterative multiply/divide unit beside the MIPS ALU. It holds the
//   architectural HI/LO registers and stalls the pipeline through `busy`.
//   MUL uses shift-add and DIV uses restoring division. Each takes one bit
//   per cycle for 32 cycles. A DIV by zero finishes after a single cycle.
//
//   Optional feature: define MD_SIGNED_EN to honour `sign`. Operands are then
//   converted to magnitudes on acceptance, and the result signs are restored
//   on the edge that enters DONE. When the macro is undefined, all operations
//   are unsigned.
//
// Ports
//   clk, reset          rising-edge clock, async active-high reset
//   start, op, sign     request (op 3'b010 MUL, 3'b011 DIV), signed request
//   in1, in2            multiplicand/dividend, multiplier/divisor
//   flush               abort of an in-flight operation (RUN only)
//   hi_we, lo_we, wdata MTHI/MTLO writes
//   busy, done          operation in flight / one-cycle result pulse
//   div_by_zero         sticky: last DIV had a zero divisor
//   hi, lo, ALUMDOut    architectural registers and {hi, lo}
//   dbg_state_o         current FSM state (IDLE=0, RUN=1, DONE=2)
//
// Handshake: `start` is a request with no ready. It is taken on a clock edge
// only while busy=0 (IDLE or DONE) and op is MUL/DIV. Otherwise it is dropped.
// An accepted start takes priority over an MTHI/MTLO write in the same cycle.
module alu_md_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic        sign,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  input  logic        flush,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [63:0] ALUMDOut,
  output logic [1:0]  dbg_state_o
);

  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  state_t      state_q;
  logic        busy_q, done_q, dbz_q, is_div_q, dz_q;
  logic [31:0] hi_q, lo_q, opb_q;
  logic [63:0] acc_q;   // MUL: {accumulator, multiplier}; DIV: low half = dividend/quotient
  logic [32:0] rem_q;   // DIV partial remainder
  logic [5:0]  cnt_q;

`ifdef MD_SIGNED_EN
  logic neg_qp_q, neg_r_q;
  logic s_a, s_b;
`else
  logic unused_sign;
  assign unused_sign = sign;
`endif

  // The remainder never reaches 2^32 after a restore, so its top bit stays clear.
  logic unused_rem_msb;
  assign unused_rem_msb = rem_q[32];

  logic        accept, acc_div, acc_dz;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum, div_shift, div_diff, rem_next;
  logic [63:0] mul_next, prod_res;
  logic        div_ge;
  logic [31:0] quo_next, quo_res, rem_res;

  always_comb begin
    accept  = start && (op == OP_MUL || op == OP_DIV) && (state_q != S_RUN);
    acc_div = (op == OP_DIV);
    acc_dz  = acc_div && (in2 == 32'd0);
    a_mag   = in1;
    b_mag   = in2;
`ifdef MD_SIGNED_EN
    s_a = sign & in1[31];
    s_b = sign & in2[31];
    if (s_a) a_mag = 32'd0 - in1;
    if (s_b) b_mag = 32'd0 - in2;
`endif
    // Shift-add step: add the multiplicand when the multiplier LSB is set, then shift right.
    mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
    mul_next = {mul_sum, acc_q[31:1]};
    // Restoring step: shift in the next dividend bit and subtract if it fits.
    div_shift = {rem_q[31:0], acc_q[31]};
    div_ge    = (div_shift >= {1'b0, opb_q});
    div_diff  = div_shift - {1'b0, opb_q};
    rem_next  = div_ge ? div_diff : div_shift;
    quo_next  = {acc_q[30:0], div_ge};
    prod_res  = mul_next;
    quo_res   = quo_next;
    rem_res   = rem_next[31:0];
`ifdef MD_SIGNED_EN
    if (neg_qp_q) begin
      prod_res = 64'd0 - mul_next;
      quo_res  = 32'd0 - quo_next;
    end
    if (neg_r_q) rem_res = 32'd0 - rem_next[31:0];
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
      is_div_q <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      opb_q    <= 32'd0;
      acc_q    <= 64'd0;
      rem_q    <= 33'd0;
      cnt_q    <= 6'd0;
`ifdef MD_SIGNED_EN
      neg_qp_q <= 1'b0;
      neg_r_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (accept) begin
            state_q  <= S_RUN;
            busy_q   <= 1'b1;
            cnt_q    <= 6'd0;
            dbz_q    <= 1'b0;
            is_div_q <= acc_div;
            dz_q     <= acc_dz;
            rem_q    <= 33'd0;
            // A zero divisor keeps the raw dividend, which becomes HI unchanged.
            if (acc_dz)       acc_q <= {32'd0, in1};
            else if (acc_div) acc_q <= {32'd0, a_mag};
            else              acc_q <= {32'd0, b_mag};
            opb_q <= acc_div ? b_mag : a_mag;
`ifdef MD_SIGNED_EN
            neg_qp_q <= s_a ^ s_b;
            neg_r_q  <= s_a;
`endif
          end else begin
            state_q <= S_IDLE;
            if (hi_we) hi_q <= wdata;
            if (lo_we) lo_q <= wdata;
          end
        end
        S_RUN: begin
          if (flush) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if (dz_q) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            dbz_q   <= 1'b1;
            hi_q    <= acc_q[31:0];
            lo_q    <= 32'hFFFF_FFFF;
          end else begin
            cnt_q <= cnt_q + 6'd1;
            if (is_div_q) begin
              acc_q <= {32'd0, quo_next};
              rem_q <= rem_next;
            end else begin
              acc_q <= mul_next;
            end
            if (cnt_q == 6'd31) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              if (is_div_q) begin
                lo_q <= quo_res;
                hi_q <= rem_res;
              end else begin
                hi_q <= prod_res[63:32];
                lo_q <= prod_res[31:0];
              end
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign ALUMDOut    = {hi_q, lo_q};
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_alu_md_sequencer.sv
// Bench for alu_md_sequencer: directed cases with literal results, followed by
// randomized traffic. A transaction-level model predicts every output.
module tb_alu_md_sequencer;

`ifdef MD_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0, sign = 1'b0, flush = 1'b0, hi_we = 1'b0, lo_we = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] in1 = 32'd0, in2 = 32'd0, wdata = 32'd0;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;
  logic [63:0] ALUMDOut;
  logic [1:0]  dbg_state_unused;

  always #5 clk = ~clk;

  alu_md_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .sign(sign),
    .in1(in1), .in2(in2), .flush(flush), .hi_we(hi_we), .lo_we(lo_we),
    .wdata(wdata), .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .hi(hi), .lo(lo), .ALUMDOut(ALUMDOut), .dbg_state_o(dbg_state_unused)
  );

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Returns {div_by_zero, hi, lo} for an accepted request.
  function automatic logic [64:0] model_result(input logic [2:0] o, input logic s,
                                               input logic [31:0] a, input logic [31:0] b);
    logic [63:0]        p;
    logic signed [63:0] sa, sb, sq, sr;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    if (o == OP_MUL) begin
      if (SIGNED_EN && s) p = sa * sb;
      else                p = {32'd0, a} * {32'd0, b};
      model_result = {1'b0, p};
    end else if (b == 32'd0) begin
      model_result = {1'b1, a, 32'hFFFF_FFFF};
    end else if (SIGNED_EN && s) begin
      sq = sa / sb;
      sr = sa % sb;
      model_result = {1'b0, sr[31:0], sq[31:0]};
    end else begin
      model_result = {1'b0, a % b, a / b};
    end
  endfunction

  logic [31:0] m_hi = 32'd0, m_lo = 32'd0, r_hi = 32'd0, r_lo = 32'd0;
  logic        m_dbz = 1'b0, m_done = 1'b0, r_dz = 1'b0;
  int          m_remain = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_hi = 32'd0; m_lo = 32'd0; m_dbz = 1'b0; m_done = 1'b0; m_remain = 0;
    end else begin
      m_done = 1'b0;
      if (m_remain > 0) begin
        if (flush) m_remain = 0;
        else begin
          m_remain--;
          if (m_remain == 0) begin
            m_hi = r_hi; m_lo = r_lo; m_done = 1'b1;
            if (r_dz) m_dbz = 1'b1;
          end
        end
      end else if (start && (op == OP_MUL || op == OP_DIV)) begin
        {r_dz, r_hi, r_lo} = model_result(op, sign, in1, in2);
        m_dbz    = 1'b0;
        m_remain = r_dz ? 1 : 32;
      end else begin
        if (hi_we) m_hi = wdata;
        if (lo_we) m_lo = wdata;
      end
    end
  end

  // ---------------- scoreboard: every cycle ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_busy", busy, m_remain > 0);
      chk("cyc_done", done, m_done);
      chk("cyc_dbz", div_by_zero, m_dbz);
      chk("cyc_hi", hi, m_hi);
      chk("cyc_lo", lo, m_lo);
      chk("cyc_alumdout", ALUMDOut, {m_hi, m_lo});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [2:0] o, input logic s, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; sign = s; in1 = a; in2 = b;
    @(negedge clk);
    start = 1'b0; op = 3'b000; sign = 1'b0; in1 = $urandom; in2 = $urandom;
  endtask

  task automatic wait_done(output int busy_cycles);
    int n;
    busy_cycles = 0;
    n = 0;
    while (!done && n < 100) begin
      if (busy) busy_cycles++;
      @(negedge clk);
      n++;
    end
    chk("wait_done", done, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc;
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_dbz", div_by_zero, 1'b0);
    chk("rst_hilo", ALUMDOut, 64'd0);
    cmp_en = 1'b1;

    // Full-range unsigned multiply.
    issue(OP_MUL, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(bc);
    chk("mul_busy_cycles", bc, 32);
    chk("mul_ff_hi", hi, 32'hFFFF_FFFE);
    chk("mul_ff_lo", lo, 32'h0000_0001);
    @(negedge clk);
    chk("mul_done_single", done, 1'b0);

    // Division, then divide by zero, then a MUL clears the flag.
    issue(OP_DIV, 1'b0, 32'd100, 32'd7);
    wait_done(bc);
    chk("div_100_7_lo", lo, 32'd14);
    chk("div_100_7_hi", hi, 32'd2);
    issue(OP_DIV, 1'b0, 32'd5, 32'd0);
    wait_done(bc);
    chk("dz_busy_cycles", bc, 1);
    chk("dz_lo", lo, 32'hFFFF_FFFF);
    chk("dz_hi", hi, 32'd5);
    chk("dz_flag", div_by_zero, 1'b1);
    issue(OP_MUL, 1'b0, 32'd2, 32'd3);
    chk("dz_cleared", div_by_zero, 1'b0);
    wait_done(bc);
    chk("mul_2_3_lo", lo, 32'd6);

    // Start while busy is dropped. A start in the DONE cycle is taken at once.
    @(negedge clk);
    issue(OP_MUL, 1'b0, 32'd1000, 32'd3000);
    repeat (9) @(negedge clk);
    issue(OP_MUL, 1'b0, 32'd7, 32'd9);
    wait_done(bc);
    chk("ignored_start_lo", lo, 32'h002D_C6C0);
    chk("ignored_start_hi", hi, 32'd0);
    issue(OP_DIV, 1'b0, 32'd50, 32'd5);
    chk("done_restart_busy", busy, 1'b1);
    chk("done_restart_done", done, 1'b0);
    wait_done(bc);
    chk("div_50_5_lo", lo, 32'd10);

    // Preload via MTHI/MTLO, then flush a DIV in mid-flight.
    @(negedge clk);
    hi_we = 1'b1; wdata = 32'hAAAA_0000;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h0000_BBBB;
    @(negedge clk);
    lo_we = 1'b0;
    chk("mt_hi", hi, 32'hAAAA_0000);
    chk("mt_lo", lo, 32'h0000_BBBB);
    issue(OP_DIV, 1'b0, 32'd1000, 32'd3);
    repeat (14) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", busy, 1'b0);
    chk("flush_done", done, 1'b0);
    chk("flush_hilo", ALUMDOut, 64'hAAAA_0000_0000_BBBB);

    // Asynchronous reset between edges in the middle of a MUL.
    issue(OP_MUL, 1'b0, 32'h1234, 32'h5678);
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_done", done, 1'b0);
    chk("async_rst_dbz", div_by_zero, 1'b0);
    chk("async_rst_hilo", ALUMDOut, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    issue(OP_MUL, 1'b0, 32'd3, 32'd4);
    wait_done(bc);
    chk("mul_3_4_lo", lo, 32'd12);
    chk("mul_3_4_hi", hi, 32'd0);

`ifdef MD_SIGNED_EN
    issue(OP_DIV, 1'b1, 32'hFFFF_FFF9, 32'd2);
    wait_done(bc);
    chk("sdiv_lo", lo, 32'hFFFF_FFFD);
    chk("sdiv_hi", hi, 32'hFFFF_FFFF);
    issue(OP_MUL, 1'b1, 32'hFFFF_FFFD, 32'd5);
    wait_done(bc);
    chk("smul", ALUMDOut, 64'hFFFF_FFFF_FFFF_FFF1);
    issue(OP_DIV, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(bc);
    chk("sdiv_min_lo", lo, 32'h8000_0000);
    chk("sdiv_min_hi", hi, 32'd0);
`else
    issue(OP_DIV, 1'b1, 32'hFFFF_FFF9, 32'd2);
    wait_done(bc);
    chk("udiv_signreq_lo", lo, 32'h7FFF_FFFC);
    chk("udiv_signreq_hi", hi, 32'd1);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      int r;
      r     = $urandom_range(0, 5);
      start = ($urandom_range(0, 3) == 0);
      op    = (r < 2) ? OP_MUL : (r < 4) ? OP_DIV : 3'($urandom_range(0, 7));
      sign  = 1'($urandom_range(0, 1));
      in1   = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 300)) : $urandom;
      case ($urandom_range(0, 5))
        0:       in2 = 32'd0;
        1, 2:    in2 = 32'($urandom_range(1, 40));
        default: in2 = $urandom;
      endcase
      flush = ($urandom_range(0, 39) == 0);
      hi_we = ($urandom_range(0, 5) == 0);
      lo_we = ($urandom_range(0, 5) == 0);
      wdata = $urandom;
      @(negedge clk);
    end
    start = 1'b0; flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    repeat (40) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
